fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-side consumer of the execute-stage branch resolution (branch_taken / pc_target).
//  Owns the architectural fetch PC, issues in-order instruction-memory requests and drops
//  wrong-path responses after a redirect. Buffers fetched instructions toward decode.
//  Sits between the imem port and decode; redirect inputs come from the branch unit.
// PARAMETERS
//  XLEN       64      datapath / PC width
//  RESET_PC   'h0     first fetch address after reset (must be 4-byte aligned)
//  IFQ_DEPTH  2       max in-flight requests + buffered instructions (power of 2, >=2)
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  redirect_valid  in   1     branch_taken from execute; pc_target sampled only when 1
//  redirect_pc     in   XLEN  branch target (value is don't-care when redirect_valid=0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request
//  imem_req_addr   out  XLEN  fetch address
//  imem_rsp_valid  in   1     response valid (in order, no backpressure)
//  imem_rsp_data   in   32    instruction word
//  if_valid        out  1     instruction valid toward decode
//  if_ready        in   1     decode accepts
//  if_pc           out  XLEN  PC of presented instruction
//  if_instr        out  32    instruction word
//  if_fault        out  1     presented entry is an instruction-address-misaligned fault
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=RUN, buffer empty, in-flight count 0; all outputs 0.
//  States: RUN (issuing), MISALIGN (fetch halted, one fault entry buffered).
//  Issue (RUN): imem_req_valid=1 iff inflight+buffered < IFQ_DEPTH and !redirect_valid;
//   imem_req_addr=pc; on valid&&ready: pc+=4 (wraps mod 2^XLEN), push live=1 tag.
//  Response: pop oldest tag; live=1 -> push {pc_of_req,data} into buffer; live=0 -> drop.
//  Credit rule guarantees buffer never overflows; rsp with no in-flight tag is an error.
//  Redirect (cycle N): all in-flight tags marked live=0, buffer flushed, if_valid forced 0
//   in cycle N (no decode transfer), response arriving in N dropped. Cycle N+1:
//   pc=redirect_pc, imem_req_addr=redirect_pc if credits allow. Stale in-flight entries
//   still hold credits until their responses return.
//  redirect_pc[1:0]!=0: state->MISALIGN, no requests issued, single entry
//   {if_pc=redirect_pc, if_instr=0, if_fault=1} presented after flush; stays until next
//   redirect (which re-enters RUN, or MISALIGN again if also misaligned).
//  Decode: if_valid&&if_ready pops buffer head; first-word fall-through (0-cycle buffer
//   latency); min fetch latency req-accept -> if_valid = imem latency.
//  Simultaneous push+pop of buffer at full is legal. Back-to-back redirects each restart.
//  Async reset mid-operation: immediate return to reset state; in-flight responses after
//   reset release must not be sent by imem (system rule).
// STRUCTURE
//  rv64i_pkg: XLEN, ILEN=32, fetch state enum, FETCH_FAULT_MISALIGN encoding.
//  Sub-module fetch_buffer: sync FIFO {pc,instr,fault}, depth IFQ_DEPTH, flush input.
//  Tag queue (live bits) and credit counter inline in fetch_pc_unit.
// TESTING
//  Reset, imem ready=1, latency 1 -> req addrs 0,4,8...; if_pc/instr match, no gaps.
//  if_ready=0 for 10 cycles -> exactly IFQ_DEPTH requests issued, then stall; resume drains.
//  Redirect to 0x100 with 2 in flight -> both responses dropped, next if_pc=0x100.
//  Redirect same cycle as rsp_valid and if_ready -> rsp dropped, no decode transfer.
//  Redirect to 0x102 -> no imem reqs, if_fault=1 if_pc=0x102; redirect 0x200 -> RUN.
//  pc=2^64-4 -> next req addr 0; rst_n low mid-burst -> all outputs 0 same cycle.

Source files
------------

// File: rtl/rv64i_pkg.sv
// Shared RV64I fetch-side constants, fetch FSM state type and fault encoding.
package rv64i_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  typedef enum logic {
    FETCH_RUN      = 1'b0,
    FETCH_MISALIGN = 1'b1
  } fetch_state_e;

  localparam logic FETCH_FAULT_NONE     = 1'b0;
  localparam logic FETCH_FAULT_MISALIGN = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched entries toward decode; flush clears it and may load one entry.
module fetch_buffer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned CW   = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [Width-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [Width-1:0] o_head
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      // A push alongside a flush lands as the sole surviving entry.
      r_rd    <= '0;
      r_wr    <= AW'(i_push);
      r_count <= CW'(i_push);
      if (i_push) r_mem[0] <= i_push_data;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: credit-limited in-order imem requests, wrong-path drop after redirect,
// misaligned-target fault entry, and a decode-side buffer.
module fetch_pc_unit #(
  parameter int unsigned     XLEN      = rv64i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     IFQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_fault
);

  import rv64i_pkg::*;

  localparam int unsigned CW = $clog2(IFQ_DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = XLEN + ILEN + 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_stale;

  logic            w_credit;
  logic            w_req_fire;
  logic            w_rsp_pop;
  logic            w_rsp_live;
  logic            w_redir_mis;
  logic            w_push;
  logic            w_pop;
  logic            w_buf_empty;
  logic [CW-1:0]   w_buf_count;
  logic [CW-1:0]   w_live;
  logic [XLEN-1:0] w_rsp_pc;
  logic [EW-1:0]   w_push_data;
  logic [EW-1:0]   w_head;

  assign w_credit = ({1'b0, r_inflight} + {1'b0, w_buf_count}) < SW'(IFQ_DEPTH);

  assign imem_req_valid = rst_n && (r_state == FETCH_RUN) && !redirect_valid && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A redirect kills everything in flight, so dead tags are always the oldest ones:
  // a count of them replaces per-tag live bits, and live requests are consecutive
  // words ending just below r_pc.
  assign w_rsp_pop   = imem_rsp_valid && (r_inflight != '0);
  assign w_rsp_live  = w_rsp_pop && !redirect_valid && (r_stale == '0);
  assign w_live      = r_inflight - r_stale;
  assign w_rsp_pc    = r_pc - (XLEN'(w_live) << 2);
  assign w_redir_mis = redirect_valid && is_misaligned(redirect_pc[1:0]);

  always_comb begin
    w_push_data = {w_rsp_pc, imem_rsp_data, FETCH_FAULT_NONE};
    if (w_redir_mis) w_push_data = {redirect_pc, ILEN'(0), FETCH_FAULT_MISALIGN};
  end

  assign w_push = w_rsp_live || w_redir_mis;

  // The fault entry is sticky: decode may accept it, but it stays until the next redirect.
  assign if_valid = !w_buf_empty && !redirect_valid;
  assign w_pop    = if_valid && if_ready && (r_state == FETCH_RUN);
  assign if_pc    = if_valid ? w_head[EW-1 -: XLEN] : '0;
  assign if_instr = if_valid ? w_head[ILEN:1] : '0;
  assign if_fault = if_valid && w_head[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH_RUN;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_stale    <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_pop);
      if (redirect_valid) begin
        r_stale <= r_inflight - CW'(w_rsp_pop);
        r_pc    <= redirect_pc;
        r_state <= w_redir_mis ? FETCH_MISALIGN : FETCH_RUN;
      end else begin
        if (w_rsp_pop && (r_stale != '0)) r_stale <= r_stale - CW'(1);
        if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      end
    end
  end

  fetch_buffer #(
    .Width (EW),
    .Depth (IFQ_DEPTH)
  ) u_fetch_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_empty     (w_buf_empty),
    .o_count     (w_buf_count),
    .o_head      (w_head)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: queue-based fetch model checked every cycle, an in-order imem
// responder with adjustable latency, and directed scenarios with literal expectations.
module tb_fetch_pc_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;

  fetch_pc_unit #(
    .XLEN      (64),
    .RESET_PC  (64'h0),
    .IFQ_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] addr; bit live;} tag_t;
  typedef struct {logic [63:0] pc; logic [31:0] instr; bit fault;} ent_t;
  typedef struct {logic [63:0] addr; int due;} env_t;

  int total = 0;
  int bad   = 0;

  tag_t        m_tags[$];
  ent_t        m_buf[$];
  bit          m_mis = 1'b0;
  logic [63:0] m_pc  = '0;
  bit          e_req_valid, e_if_valid;

  env_t        env_q[$];
  bit          env_fire = 1'b0;
  logic [63:0] env_addr;
  int          env_due;
  int          cyc = 0;
  int          lat = 1;

  logic [63:0] obs_req[$];
  ent_t        obs_if[$];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_req(input string name, input int k, input logic [63:0] exp);
    if (obs_req.size() > k) check(name, obs_req[k], exp);
    else begin
      total++; bad++;
      $display("FAIL %s: only %0d requests seen, expected index %0d", name, obs_req.size(), k);
    end
  endtask

  task automatic check_ifpc(input string name, input int k, input logic [63:0] exp);
    if (obs_if.size() > k) check(name, obs_if[k].pc, exp);
    else begin
      total++; bad++;
      $display("FAIL %s: only %0d transfers seen, expected index %0d", name, obs_if.size(), k);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      e_req_valid = !m_mis && !redirect_valid && (m_tags.size() + m_buf.size() < DEPTH);
      e_if_valid  = (m_buf.size() != 0) && !redirect_valid;
      check("req_valid", 64'(imem_req_valid), 64'(e_req_valid));
      if (e_req_valid) check("req_addr", imem_req_addr, m_pc);
      check("if_valid", 64'(if_valid), 64'(e_if_valid));
      if (e_if_valid) begin
        check("if_pc", if_pc, m_buf[0].pc);
        check("if_instr", 64'(if_instr), 64'(m_buf[0].instr));
        check("if_fault", 64'(if_fault), 64'(m_buf[0].fault));
      end
      env_fire = imem_req_valid && imem_req_ready;
      env_addr = imem_req_addr;
      env_due  = cyc + lat;
      if (env_fire) obs_req.push_back(imem_req_addr);
      if (if_valid && if_ready) begin
        ent_t o;
        o.pc = if_pc; o.instr = if_instr; o.fault = if_fault;
        obs_if.push_back(o);
      end
    end
  end

  // Model state update and imem responder.
  always @(posedge clk) begin
    tag_t t;
    ent_t e;
    env_t ev;
    if (rst_n) begin
      if (redirect_valid) begin
        if (imem_rsp_valid) begin
          if (m_tags.size() == 0) begin
            total++; bad++; $display("FAIL rsp_tag: response with nothing in flight");
          end else void'(m_tags.pop_front());
        end
        foreach (m_tags[i]) m_tags[i].live = 1'b0;
        m_buf.delete();
        m_pc  = redirect_pc;
        m_mis = (redirect_pc[1:0] != 2'b00);
        if (m_mis) begin
          e.pc = redirect_pc; e.instr = '0; e.fault = 1'b1;
          m_buf.push_back(e);
        end
      end else begin
        if (e_if_valid && if_ready && !m_mis) void'(m_buf.pop_front());
        if (imem_rsp_valid) begin
          if (m_tags.size() == 0) begin
            total++; bad++; $display("FAIL rsp_tag: response with nothing in flight");
          end else begin
            t = m_tags.pop_front();
            if (t.live) begin
              e.pc = t.addr; e.instr = imem_rsp_data; e.fault = 1'b0;
              m_buf.push_back(e);
            end
          end
        end
        if (e_req_valid && imem_req_ready) begin
          t.addr = m_pc; t.live = 1'b1;
          m_tags.push_back(t);
          m_pc = m_pc + 64'd4;
        end
      end
      if (imem_rsp_valid && env_q.size() != 0) void'(env_q.pop_front());
      if (env_fire) begin
        ev.addr = env_addr; ev.due = env_due;
        env_q.push_back(ev);
      end
      cyc++;
      #1;
      if (rst_n && env_q.size() != 0 && env_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(env_q[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic model_reset();
    m_tags.delete(); m_buf.delete(); env_q.delete();
    m_mis = 1'b0; m_pc = '0; env_fire = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int n0;
    int nr;
    bit found;

    // Reset state
    #20;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, 64'h0);
    #7 rst_n = 1'b1;

    // Sequential fetch, imem latency 1
    tick(12);
    check_req("seq_req0", 0, 64'h0);
    check_req("seq_req1", 1, 64'h4);
    check_req("seq_req2", 2, 64'h8);
    check_req("seq_req3", 3, 64'hC);
    check_ifpc("seq_if0", 0, 64'h0);
    check_ifpc("seq_if1", 1, 64'h4);
    check_ifpc("seq_if2", 2, 64'h8);
    if (obs_if.size() > 1) check("seq_instr1", 64'(obs_if[1].instr), 64'h1357_9BDB);

    // Decode stall: exactly DEPTH requests from an empty pipe, then resume
    imem_req_ready = 1'b0;
    tick(4);
    imem_req_ready = 1'b1;
    if_ready = 1'b0;
    nr = obs_req.size();
    tick(10);
    check("stall_reqs", 64'(obs_req.size() - nr), 64'(DEPTH));
    if_ready = 1'b1;
    tick(8);

    // Redirect with two requests in flight
    imem_req_ready = 1'b0;
    tick(4);
    lat = 4;
    imem_req_ready = 1'b1;
    tick(2);
    n0 = obs_if.size();
    redirect_to(64'h100);
    tick(16);
    check_ifpc("redir_first_pc", n0, 64'h100);

    // Redirect in the same cycle as a response and a would-be decode transfer
    lat = 1;
    tick(4);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_rsp_valid && m_buf.size() != 0) found = 1'b1;
      else tick(1);
    end
    if (!found) begin
      total++; bad++; $display("FAIL redir_rsp_setup: no response cycle found");
    end
    n0 = obs_if.size();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    #1 check("redir_if_valid", 64'(if_valid), 64'd0);
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    check_ifpc("redir_rsp_first_pc", n0, 64'h300);

    // Misaligned target: halt fetching, present a sticky fault entry
    nr = obs_req.size();
    redirect_to(64'h102);
    tick(6);
    check("mis_no_reqs", 64'(obs_req.size() - nr), 64'd0);
    check("mis_if_valid", 64'(if_valid), 64'd1);
    check("mis_if_pc", if_pc, 64'h102);
    check("mis_if_fault", 64'(if_fault), 64'd1);
    check("mis_if_instr", 64'(if_instr), 64'd0);
    nr = obs_req.size();
    redirect_to(64'h200);
    tick(6);
    check_req("run_again_req", nr, 64'h200);

    // PC wraps past the top of the address space
    tick(4);
    nr = obs_req.size();
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    tick(8);
    check_req("wrap_req0", nr, 64'hFFFF_FFFF_FFFF_FFFC);
    check_req("wrap_req1", nr + 1, 64'h0);

    // Asynchronous reset mid-burst
    tick(3);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_req_valid", 64'(imem_req_valid), 64'd0);
    check("arst_req_addr", imem_req_addr, 64'h0);
    check("arst_if_valid", 64'(if_valid), 64'd0);
    check("arst_if_pc", if_pc, 64'h0);
    check("arst_if_instr", 64'(if_instr), 64'd0);
    check("arst_if_fault", 64'(if_fault), 64'd0);
    tick(2);
    nr = obs_req.size();
    rst_n = 1'b1;
    tick(8);
    check_req("arst_first_req", nr, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
